// File: rtl/qsys_multi_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH down-counters with one-shot/continuous modes.
// Optional per-channel prescaler enabled by defining QSYS_MULTI_TIMER_PRESCALER_EN.
module qsys_multi_timer #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int RST_PERIOD = 49999,
   localparam int AW        = $clog2(NUM_CH) + 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AW-1:0]     address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [NUM_CH-1:0] irq_vec
);

   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_PERIOD);

   typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} state_t;

   logic            wr;
   logic [2:0]      reg_sel;
   logic [CHW-1:0]  ch;
   logic            ch_ok;
   logic [31:0]     rd_val [NUM_CH];
   logic [31:0]     rd_nxt;

   assign wr      = chipselect & ~write_n;
   assign reg_sel = address[2:0];

   generate
      if (NUM_CH > 1) begin : g_ch_multi
         assign ch    = address[AW-1:3];
         assign ch_ok = (int'(ch) < NUM_CH);
      end else begin : g_ch_single
         assign ch    = '0;
         assign ch_ok = 1'b1;
      end
   endgenerate

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      logic             sel, wr_stat, wr_ctrl, wr_per, wr_snap, start, stop;
      logic             to, ito, cont, tick, expire;
      logic [CNT_W-1:0] period, count, snap;
      logic [31:0]      pre_rd, rd;
      state_t           state, state_nxt;

      assign sel     = wr & ch_ok & (ch == CHW'(i));
      assign wr_stat = sel & (reg_sel == 3'd0);
      assign wr_ctrl = sel & (reg_sel == 3'd1);
      assign wr_per  = sel & (reg_sel == 3'd2);
      assign wr_snap = sel & (reg_sel == 3'd3);
      assign start   = wr_ctrl & writedata[2];
      assign stop    = wr_ctrl & writedata[3];

`ifdef QSYS_MULTI_TIMER_PRESCALER_EN
      logic       wr_pre;
      logic [7:0] prescale, pcnt;

      assign wr_pre = sel & (reg_sel == 3'd4);
      assign tick   = (state == RUNNING) & (pcnt == prescale);
      assign pre_rd = 32'(prescale);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            prescale <= '0;
            pcnt     <= '0;
         end else begin
            if (wr_pre) prescale <= writedata[7:0];
            if (wr_pre | start | stop | wr_per) pcnt <= '0;
            else if (state == RUNNING)          pcnt <= tick ? 8'd0 : pcnt + 8'd1;
         end
      end
`else
      assign tick   = (state == RUNNING);
      assign pre_rd = '0;
`endif

      assign expire = tick & (count == '0);

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) state <= IDLE;
         else       state <= state_nxt;
      end

      // NOTE: next state is defaulted first so no path through the block infers a latch.
      always_comb begin
         state_nxt = state;
         case (state)
            IDLE:    if (start) state_nxt = RUNNING;
            RUNNING: begin
               if (wr_per)              state_nxt = IDLE;
               else if (start)          state_nxt = RUNNING;  // START beats STOP
               else if (stop)           state_nxt = IDLE;
               else if (expire & ~cont) state_nxt = IDLE;
            end
         endcase
      end

      // NOTE: these are individual control flops, not a memory, so every one gets a reset value.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            to     <= 1'b0;
            ito    <= 1'b0;
            cont   <= 1'b0;
            period <= RST_VAL;
            count  <= RST_VAL;
            snap   <= '0;
         end else begin
            if (expire)       to <= 1'b1;
            else if (wr_stat) to <= 1'b0;
            if (wr_ctrl) begin
               ito  <= writedata[0];
               cont <= writedata[1];
            end
            if (wr_per) begin
               period <= writedata[CNT_W-1:0];
               count  <= writedata[CNT_W-1:0];
            end else if (expire) begin
               count <= period;
            end else if (tick) begin
               count <= count - CNT_W'(1);
            end
            if (wr_snap) snap <= count;
         end
      end

      always_comb begin
         rd = '0;
         case (reg_sel)
            3'd0:    rd = {30'd0, (state == RUNNING), to};
            3'd1:    rd = {30'd0, cont, ito};
            3'd2:    rd = 32'(period);
            3'd3:    rd = 32'(snap);
            3'd4:    rd = pre_rd;
            default: rd = '0;
         endcase
      end

      assign rd_val[i]  = rd;
      assign irq_vec[i] = to & ito;
   end

   always_comb begin
      rd_nxt = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch_ok && (ch == CHW'(i))) rd_nxt = rd_val[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= '0;
      else       readdata <= rd_nxt;
   end

   assign irq = |irq_vec;

endmodule
